// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the framebuffer scan-out reader.
package fb_pkg;
  localparam int unsigned H_LOG      = 80;
  localparam int unsigned V_LOG      = 60;
  localparam int unsigned SCALE      = 8;
  localparam int unsigned DATA_WIDTH = 6;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned RAMLENGTH  = H_LOG * V_LOG / DATA_WIDTH;
  localparam int unsigned ROW_WORDS  = H_LOG / DATA_WIDTH;
  localparam int unsigned ROW_BITS   = H_LOG % DATA_WIDTH;
  localparam int unsigned BIT_W      = $clog2(DATA_WIDTH);
  localparam int unsigned SX_W       = $clog2(SCALE);

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    WAIT0,
    FETCH1,
    WAIT1,
    ACTIVE
  } state_e;
endpackage

// File: rtl/fb_scan_reader_if.sv
// Read port towards the shared framebuffer RAM arbiter.
interface fb_scan_reader_if;
  logic                          rd_req;
  logic                          rd_gnt;
  logic [fb_pkg::ADDR_WIDTH-1:0] rd_addr;
  logic [fb_pkg::DATA_WIDTH-1:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_gnt, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_gnt, output rd_data);
endinterface

// File: rtl/fb_row_base.sv
// Word/bit start position of the current logical row, stepped once every SCALE lines.
module fb_row_base
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] base_word_o,
  output logic [BIT_W-1:0]      base_bit_o
);
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [SX_W-1:0]       sub_q;
  logic [BIT_W:0]        bit_sum;

  always_comb begin
    bit_sum = {1'b0, bit_q} + (BIT_W+1)'(ROW_BITS);
    word_d  = word_q + ADDR_WIDTH'(ROW_WORDS);
    bit_d   = bit_sum[BIT_W-1:0];
    if (bit_sum >= (BIT_W+1)'(DATA_WIDTH)) begin
      bit_d  = BIT_W'(bit_sum - (BIT_W+1)'(DATA_WIDTH));
      word_d = word_q + ADDR_WIDTH'(ROW_WORDS + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      bit_q  <= '0;
      sub_q  <= '0;
    end else if (clear_i) begin
      word_q <= '0;
      bit_q  <= '0;
      sub_q  <= '0;
    end else if (advance_i) begin
      if (sub_q == SX_W'(SCALE - 1)) begin
        sub_q  <= '0;
        word_q <= word_d;
        bit_q  <= bit_d;
      end else begin
        sub_q <= sub_q + SX_W'(1);
      end
    end
  end

  assign base_word_o = word_q;
  assign base_bit_o  = bit_q;
endmodule

// File: rtl/fb_scan_reader.sv
// Fetches framebuffer words in raster order and serialises them as an upscaled pixel stream.
module fb_scan_reader
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce_i,
  input  logic             frame_start_i,
  input  logic             line_start_i,
  input  logic             de_i,
  fb_scan_reader_if.master rd,
  output logic             pix_out_o,
  output logic             pix_valid_o,
  output logic             underflow_o
);
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_ptr_q, rd_addr_q, base_word, start_word, pf_addr;
  logic [BIT_W-1:0]      bit_idx_q, base_bit, start_bit;
  logic [SX_W-1:0]       sx_q;
  logic [DATA_WIDTH-1:0] cur_word_q, nxt_word_q;
  logic                  nxt_valid_q, pf_req_q, pf_wait_q, rd_req_q, de_prev_q;
  logic                  pix_out_q, pix_valid_q, underflow_q;
  logic                  pix_req, de_fall, row_adv;

  assign pix_req    = pix_ce_i & de_i;
  assign de_fall    = pix_ce_i & ~de_i & de_prev_q;
  assign row_adv    = de_fall & (state_q != IDLE);
  // frame_start coinciding with line_start must see the cleared base, not the registered one
  assign start_word = frame_start_i ? '0 : base_word;
  assign start_bit  = frame_start_i ? '0 : base_bit;
  assign pf_addr    = cur_ptr_q + ADDR_WIDTH'(2);

  fb_row_base u_row_base (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (frame_start_i),
    .advance_i   (row_adv),
    .base_word_o (base_word),
    .base_bit_o  (base_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_ptr_q   <= '0;
      rd_addr_q   <= '0;
      bit_idx_q   <= '0;
      sx_q        <= '0;
      cur_word_q  <= '0;
      nxt_word_q  <= '0;
      nxt_valid_q <= 1'b0;
      pf_req_q    <= 1'b0;
      pf_wait_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      de_prev_q   <= 1'b0;
      pix_out_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pix_valid_q <= pix_req;
      pix_out_q   <= 1'b0;
      if (pix_ce_i) de_prev_q <= de_i;
      if (pix_req && state_q != ACTIVE) underflow_q <= 1'b1;

      if (line_start_i) begin
        cur_ptr_q   <= start_word;
        bit_idx_q   <= start_bit;
        sx_q        <= '0;
        rd_req_q    <= 1'b1;
        rd_addr_q   <= start_word;
        nxt_valid_q <= 1'b0;
        pf_req_q    <= 1'b0;
        pf_wait_q   <= 1'b0;
        state_q     <= FETCH0;
      end else if (row_adv) begin
        rd_req_q  <= 1'b0;
        pf_req_q  <= 1'b0;
        pf_wait_q <= 1'b0;
        state_q   <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: ;
          FETCH0: if (rd.rd_gnt) begin
            rd_req_q <= 1'b0;
            state_q  <= WAIT0;
          end
          WAIT0: begin
            cur_word_q <= rd.rd_data;
            rd_req_q   <= 1'b1;
            rd_addr_q  <= cur_ptr_q + ADDR_WIDTH'(1);
            state_q    <= FETCH1;
          end
          FETCH1: if (rd.rd_gnt) begin
            rd_req_q <= 1'b0;
            state_q  <= WAIT1;
          end
          WAIT1: begin
            nxt_word_q  <= rd.rd_data;
            nxt_valid_q <= 1'b1;
            state_q     <= ACTIVE;
          end
          ACTIVE: begin
            if (pf_req_q && rd.rd_gnt) begin
              pf_req_q  <= 1'b0;
              rd_req_q  <= 1'b0;
              pf_wait_q <= 1'b1;
            end
            if (pf_wait_q) begin
              nxt_word_q  <= rd.rd_data;
              nxt_valid_q <= 1'b1;
              pf_wait_q   <= 1'b0;
            end
            if (pix_req) begin
              pix_out_q <= cur_word_q[bit_idx_q];
              if (sx_q == SX_W'(SCALE - 1)) begin
                sx_q <= '0;
                if (bit_idx_q == BIT_W'(DATA_WIDTH - 1)) begin
                  if (!nxt_valid_q) begin
                    pix_out_q   <= 1'b0;
                    underflow_q <= 1'b1;
                  end
                  cur_word_q  <= nxt_word_q;
                  bit_idx_q   <= '0;
                  cur_ptr_q   <= cur_ptr_q + ADDR_WIDTH'(1);
                  nxt_valid_q <= 1'b0;
                  // past the last RAM word the tail of the frame reads as zeros
                  if (pf_addr > ADDR_WIDTH'(RAMLENGTH - 1)) begin
                    nxt_word_q  <= '0;
                    nxt_valid_q <= 1'b1;
                  end else if (!pf_req_q && !pf_wait_q) begin
                    pf_req_q  <= 1'b1;
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= pf_addr;
                  end
                end else begin
                  bit_idx_q <= bit_idx_q + BIT_W'(1);
                end
              end else begin
                sx_q <= sx_q + SX_W'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      if (frame_start_i) underflow_q <= 1'b0;
    end
  end

  assign rd.rd_req   = rd_req_q;
  assign rd.rd_addr  = rd_addr_q;
  assign pix_out_o   = pix_out_q;
  assign pix_valid_o = pix_valid_q;
  assign underflow_o = underflow_q;
endmodule
